// File: rtl/chain_add_pkg.sv
// Shared types and default sizing for the chunked carry-chain add/sub scheduler.
package chain_add_pkg;

  localparam int unsigned CHUNK_W_DEF    = 16;
  localparam int unsigned NUM_CHUNKS_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/chain_add_sched_if.sv
// Request/response bundle between two requesters, the scheduler and the result consumer.
interface chain_add_sched_if
  import chain_add_pkg::*;
#(
  parameter int unsigned OPW = CHUNK_W_DEF * NUM_CHUNKS_DEF
);

  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [2*OPW-1:0] req_a;
  logic [2*OPW-1:0] req_b;
  logic [1:0]       req_sub;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [OPW-1:0]   rsp_sum;
  logic             rsp_cout;
  logic             rsp_ovf;
  logic             busy;

  modport master (
    output req_valid, req_a, req_b, req_sub, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, req_sub, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf, busy
  );

endinterface

// File: rtl/chain_add_slice.sv
// One W-bit carry-chain slice: A + (B ^ sub) + cin, with carry-out and signed overflow of the slice MSB.
module chain_add_slice #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  input  logic         cin,
  output logic [W-1:0] sum_c,
  output logic         cout_c,
  output logic         ovf_c
);

  logic [W-1:0] b_x;

  always_comb begin
    b_x              = b ^ {W{sub}};
    {cout_c, sum_c}  = (W+1)'(a) + (W+1)'(b_x) + (W+1)'(cin);
    // Same-sign operands producing an opposite-sign result == carry into MSB xor carry out.
    ovf_c            = (a[W-1] == b_x[W-1]) && (sum_c[W-1] != a[W-1]);
  end

endmodule

// File: rtl/chain_add_sched.sv
// Two-requester round-robin scheduler feeding a single multi-cycle chunked adder/subtractor.
module chain_add_sched
  import chain_add_pkg::*;
#(
  parameter  int unsigned CHUNK_W    = CHUNK_W_DEF,
  parameter  int unsigned NUM_CHUNKS = NUM_CHUNKS_DEF,
  localparam int unsigned OPW        = CHUNK_W * NUM_CHUNKS
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [2*OPW-1:0] req_a,
  input  logic [2*OPW-1:0] req_b,
  input  logic [1:0]       req_sub,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [OPW-1:0]   rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_ovf,
  output logic             busy
);

  localparam int unsigned      IDX_W    = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

  state_t             state;
  logic [OPW-1:0]     a_q;
  logic [OPW-1:0]     b_q;
  logic               sub_q;
  logic               id_q;
  logic               carry;
  logic               ovf_q;
  logic               flush;
  logic               last_grant;
  logic [IDX_W-1:0]   idx;

  logic [1:0]         grant;
  logic               sel;
  logic [CHUNK_W-1:0] s;
  logic               c;
  logic               slice_ovf;

  // Round-robin grant, only offered while idle.
  always_comb begin
    grant = 2'b00;
    if (state == IDLE) begin
      if (req_valid == 2'b11) grant = last_grant ? 2'b01 : 2'b10;
      else                    grant = req_valid;
    end
  end

  assign req_ready = grant;
  assign sel       = grant[1];
  assign busy      = (state != IDLE);

  chain_add_slice #(.W(CHUNK_W)) u_slice (
    .a      (a_q[CHUNK_W-1:0]),
    .b      (b_q[CHUNK_W-1:0]),
    .sub    (sub_q),
    .cin    (carry),
    .sum_c  (s),
    .cout_c (c),
    .ovf_c  (slice_ovf)
  );

  // Operands shift down one chunk per cycle; result chunks enter rsp_sum from the top.
  // One extra RUN cycle (flush) after the last chunk publishes the response.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      sub_q      <= 1'b0;
      id_q       <= 1'b0;
      carry      <= 1'b0;
      ovf_q      <= 1'b0;
      flush      <= 1'b0;
      last_grant <= 1'b1;
      idx        <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_sum    <= '0;
      rsp_cout   <= 1'b0;
      rsp_ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant != 2'b00) begin
            a_q        <= sel ? req_a[2*OPW-1:OPW] : req_a[OPW-1:0];
            b_q        <= sel ? req_b[2*OPW-1:OPW] : req_b[OPW-1:0];
            sub_q      <= req_sub[sel];
            carry      <= req_sub[sel];
            id_q       <= sel;
            last_grant <= sel;
            idx        <= '0;
            flush      <= 1'b0;
            state      <= RUN;
          end
        end
        RUN: begin
          if (!flush) begin
            rsp_sum <= (rsp_sum >> CHUNK_W) | (OPW'(s) << (OPW - CHUNK_W));
            a_q     <= a_q >> CHUNK_W;
            b_q     <= b_q >> CHUNK_W;
            carry   <= c;
            ovf_q   <= slice_ovf;
            if (idx == LAST_IDX) flush <= 1'b1;
            else                 idx   <= idx + IDX_W'(1);
          end else begin
            rsp_valid <= 1'b1;
            rsp_id    <= id_q;
            rsp_cout  <= carry;
            rsp_ovf   <= ovf_q;
            idx       <= '0;
            flush     <= 1'b0;
            state     <= DONE;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
